// File: rtl/arm_fetch_pkg.sv
// arm_fetch_pkg: shared fetch FSM states, reset PC default and word-alignment helper
package arm_fetch_pkg;
   typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH} fetch_state_t;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int unsigned WORD_BYTES = 4;
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~(WORD_BYTES - 32'd1);
   endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory read port, one outstanding read at a time
// Signals: MemReq (1-cycle request pulse), MemAdr (word address, valid with MemReq),
//   MemRdata/MemRvalid (response, at least one cycle after the request).
// Modports: master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if;
   logic        MemReq;
   logic [31:0] MemAdr;
   logic [31:0] MemRdata;
   logic        MemRvalid;
   modport master (output MemReq, MemAdr, input MemRdata, MemRvalid);
   modport slave  (input MemReq, MemAdr, output MemRdata, MemRvalid);
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: one-entry {valid, tag, data} prefetch buffer with fill, hit compare and invalidate
// Ports: clk, reset (sync, active-high); fill/fill_tag/fill_data load the entry;
//   inval clears it; lookup is compared against the tag to give hit; valid/tag/data expose the entry.
// Only built when INSTR_PREFETCH_EN is defined.
`ifdef INSTR_PREFETCH_EN
module fetch_buffer (
   input  logic        clk,
   input  logic        reset,
   input  logic        fill,
   input  logic        inval,
   input  logic [31:0] fill_tag,
   input  logic [31:0] fill_data,
   input  logic [31:0] lookup,
   output logic        valid,
   output logic        hit,
   output logic [31:0] tag,
   output logic [31:0] data
);
   logic        valid_q, valid_d;
   logic [31:0] tag_q, tag_d, data_q, data_d;
   always_comb begin
      valid_d = fill | (valid_q & ~inval);
      tag_d   = fill ? fill_tag : tag_q;
      data_d  = fill ? fill_data : data_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end
   assign valid = valid_q;
   assign tag   = tag_q;
   assign data  = data_q;
   assign hit   = valid_q & (tag_q == lookup);
endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns PC and IR, answers controller fetches from a variable-latency instruction memory
// Ports: clk, reset (sync, active-high); IRWrite/PCWrite/PCNext from the controller;
//   Stall/Instr/PC back to it; mem (master modport) is the single-outstanding read port.
// Build option: INSTR_PREFETCH_EN adds a one-entry prefetch buffer, the PREFETCH state and a drop flag.
module instr_fetch_unit
   import arm_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               IRWrite,
   input  logic               PCWrite,
   input  logic [31:0]        PCNext,
   output logic               Stall,
   output logic [31:0]        Instr,
   output logic [31:0]        PC,
   instr_fetch_unit_if.master mem
);
   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d, instr_q, instr_d, buf_data;
   logic         issue_dem, issue_pf, pf_ok, hit, pcw_ok, capture;
`ifdef INSTR_PREFETCH_EN
   logic         pf_pend_q, pf_pend_d, drop_q, drop_d, buf_valid, buf_fill, buf_inval;
   logic [31:0]  pf_tag_q, pf_tag_d, buf_tag;
   fetch_buffer u_buf (
      .clk       (clk),
      .reset     (reset),
      .fill      (buf_fill),
      .inval     (buf_inval),
      .fill_tag  (pf_tag_q),
      .fill_data (mem.MemRdata),
      .lookup    (pc_q),
      .valid     (buf_valid),
      .hit       (hit),
      .tag       (buf_tag),
      .data      (buf_data)
   );
   // Speculative read of the already-advanced PC, one idle cycle after a fetch that also wrote PC.
   assign issue_pf = (state_q == IDLE) & ~IRWrite & pf_pend_q & ~buf_valid;
   // The outstanding prefetch is still useful: not dropped and aimed at the current PC.
   assign pf_ok    = ~drop_q & (pf_tag_q == pc_q);
   always_comb begin
      pf_pend_d = capture & PCWrite;
      pf_tag_d  = issue_pf ? pc_q : pf_tag_q;
      // A PC change away from the in-flight prefetch address makes its response useless.
      drop_d    = (state_q == PREFETCH && mem.MemRvalid) ? 1'b0 :
                  drop_q | (pcw_ok & (issue_pf | (state_q == PREFETCH)) & (PCNext != pf_tag_d));
      buf_fill  = (state_q == PREFETCH) & mem.MemRvalid & ~drop_q & ~IRWrite &
                  ~(pcw_ok & (PCNext != pf_tag_q));
      buf_inval = (capture & (state_q == IDLE)) | (pcw_ok & (PCNext != buf_tag));
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pf_pend_q <= 1'b0;
         drop_q    <= 1'b0;
         pf_tag_q  <= '0;
      end else begin
         pf_pend_q <= pf_pend_d;
         drop_q    <= drop_d;
         pf_tag_q  <= pf_tag_d;
      end
   end
`else
   assign issue_pf = 1'b0;
   assign pf_ok    = 1'b0;
   assign hit      = 1'b0;
   assign buf_data = '0;
`endif
   always_comb begin
      state_d   = state_q;
      Stall     = 1'b0;
      issue_dem = 1'b0;
      case (state_q)
         IDLE: begin
            issue_dem = IRWrite & ~hit;
            Stall     = issue_dem;
            state_d   = issue_dem ? DEMAND : issue_pf ? PREFETCH : IDLE;
         end
         DEMAND: begin
            Stall   = ~mem.MemRvalid;
            state_d = mem.MemRvalid ? IDLE : DEMAND;
         end
         default: begin
            // A fetch of the prefetched PC rides on the outstanding read instead of issuing another.
            Stall   = IRWrite & ~(mem.MemRvalid & pf_ok);
            state_d = mem.MemRvalid ? IDLE : (IRWrite & pf_ok) ? DEMAND : PREFETCH;
         end
      endcase
      pcw_ok  = PCWrite & ~Stall;
      capture = IRWrite & ~Stall;
      pc_d    = pcw_ok ? PCNext : pc_q;
      instr_d = ~capture ? instr_q : (state_q == IDLE) ? buf_data : mem.MemRdata;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end
   assign mem.MemReq = issue_dem | issue_pf;
   assign mem.MemAdr = mem.MemReq ? word_align(pc_q) : '0;
   assign Instr      = instr_q;
   assign PC         = pc_q;
endmodule
